// File: rtl/multi_tap_delay.sv
// Multi-channel, clock-enabled variable delay line with a tap-load
// handshake, fill tracking that masks stale history, and a synchronous flush.
module multi_tap_delay #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 32,
    parameter int NCH   = 2,
    parameter int TAP_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_valid,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic                   clear,
    input  logic [TAP_W-1:0]       tap_req,
    input  logic                   tap_load,
    output logic                   tap_ack,
    output logic                   tap_err,
    output logic [TAP_W-1:0]       tap_active,
    output logic [NCH*WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic [TAP_W:0]         fill
);

    localparam logic [TAP_W:0]   DEPTH_F = (TAP_W+1)'(DEPTH);
    localparam logic [TAP_W:0]   ONE_F   = (TAP_W+1)'(1);
    localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(DEPTH - 1);

    // Sample history is deliberately reset-free so it can live in shift-register
    // primitives; fill tracking guarantees none of it is flagged before it is written.
`ifdef SIMULATION
    (* shreg_extract = "yes" *) logic [WIDTH-1:0] line_q [NCH][DEPTH] = '{default: '0};
`else
    (* shreg_extract = "yes" *) logic [WIDTH-1:0] line_q [NCH][DEPTH];
`endif

    (* shreg_extract = "no" *) logic [NCH*WIDTH-1:0] dout_q;
    logic [NCH*WIDTH-1:0] dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [TAP_W:0]       fill_q, fill_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    // Shift every channel's history by one slot on each accepted sample.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            for (int c = 0; c < NCH; c++) begin
                line_q[c][0] <= din[c*WIDTH +: WIDTH];
                for (int n = 1; n < DEPTH; n++) begin
                    line_q[c][n] <= line_q[c][n-1];
                end
            end
        end
    end

    // Read the selected tap before the shift, and qualify it against the fill level.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        fill_d       = fill_q;
        if (clear) begin
            dout_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            for (int c = 0; c < NCH; c++) begin
                dout_d[c*WIDTH +: WIDTH] = line_q[c][tap_q];
            end
            dout_valid_d = (fill_q >= ({1'b0, tap_q} + ONE_F));
            fill_d       = (fill_q == DEPTH_F) ? fill_q : fill_q + ONE_F;
        end
    end

    // Tap handshake: clamp out-of-range requests and acknowledge every load.
    always_comb begin
        tap_d = tap_q;
        ack_d = 1'b0;
        err_d = 1'b0;
        if (tap_load) begin
            ack_d = 1'b1;
            if ({1'b0, tap_req} >= DEPTH_F) begin
                err_d = 1'b1;
                tap_d = MAX_TAP;
            end else begin
                tap_d = tap_req;
            end
        end
    end

    // Output, fill and tap registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            fill_q       <= '0;
            tap_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            fill_q       <= fill_d;
            tap_q        <= tap_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign fill       = fill_q;
    assign tap_active = tap_q;
    assign tap_ack    = ack_q;
    assign tap_err    = err_q;

endmodule

// File: tb/tb_multi_tap_delay.sv
// Directed bench for multi_tap_delay (DEPTH=20 so the clamp path is reachable).
module tb_multi_tap_delay;

    localparam int WIDTH = 13;
    localparam int DEPTH = 20;
    localparam int NCH   = 2;
    localparam int TAP_W = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   din_valid = 1'b0;
    logic [NCH*WIDTH-1:0]   din = '0;
    logic                   clear = 1'b0;
    logic [TAP_W-1:0]       tap_req = '0;
    logic                   tap_load = 1'b0;
    logic                   tap_ack;
    logic                   tap_err;
    logic [TAP_W-1:0]       tap_active;
    logic [NCH*WIDTH-1:0]   dout;
    logic                   dout_valid;
    logic [TAP_W:0]         fill;

    int errors = 0;
    int checks = 0;

    multi_tap_delay #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH), .TAP_W(TAP_W)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
        .tap_req(tap_req), .tap_load(tap_load), .tap_ack(tap_ack), .tap_err(tap_err),
        .tap_active(tap_active), .dout(dout), .dout_valid(dout_valid), .fill(fill)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic dv;
        logic clr;
        logic tl;
        int   treq;
        int   d0;
        int   d1;
        logic chkd;
        int   e_d0;
        int   e_d1;
        logic e_dv;
        int   e_fill;
        int   e_tap;
        logic e_ack;
        logic e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input logic dv, input logic clr, input logic tl, input int treq,
                          input int d0, input int d1, input logic chkd, input int e_d0,
                          input int e_d1, input logic e_dv, input int e_fill, input int e_tap,
                          input logic e_ack, input logic e_err);
        vec_t v;
        v.dv = dv; v.clr = clr; v.tl = tl; v.treq = treq; v.d0 = d0; v.d1 = d1;
        v.chkd = chkd; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_dv = e_dv;
        v.e_fill = e_fill; v.e_tap = e_tap; v.e_ack = e_ack; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and land 1 unit past the edge.
    task automatic applyStimulus(input logic dv, input logic clr, input logic tl,
                                 input int treq, input int d0, input int d1);
        din_valid = dv;
        clear     = clr;
        tap_load  = tl;
        tap_req   = TAP_W'(treq);
        din       = {WIDTH'(d1), WIDTH'(d0)};
        @(posedge clk);
        #1;
        tap_load  = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic checkDout(input string tag, input int e0, input int e1);
        int a0, a1;
        a0 = $signed(dout[WIDTH-1:0]);
        a1 = $signed(dout[2*WIDTH-1:WIDTH]);
        checkOutput({tag, ".dout0"}, a0, e0);
        checkOutput({tag, ".dout1"}, a1, e1);
    endtask

    task automatic checkCtl(input string tag, input logic e_dv, input int e_fill,
                            input int e_tap, input logic e_ack, input logic e_err);
        checkOutput({tag, ".dout_valid"}, int'(dout_valid), int'(e_dv));
        checkOutput({tag, ".fill"}, int'(fill), e_fill);
        checkOutput({tag, ".tap_active"}, int'(tap_active), e_tap);
        checkOutput({tag, ".tap_ack"}, int'(tap_ack), int'(e_ack));
        checkOutput({tag, ".tap_err"}, int'(tap_err), int'(e_err));
    endtask

    initial begin
        // Ramp at tap 3, then tap 0 with every-other-cycle strobes.
        addVec(0,0,1,3,  0,0,      1,0,0,       0,0,3,1,0);
        addVec(1,0,0,0,  1,-1,     0,0,0,       0,1,3,0,0);
        addVec(1,0,0,0,  2,-2,     0,0,0,       0,2,3,0,0);
        addVec(1,0,0,0,  3,-3,     0,0,0,       0,3,3,0,0);
        addVec(1,0,0,0,  4,-4,     0,0,0,       0,4,3,0,0);
        addVec(1,0,0,0,  5,-5,     1,1,-1,      1,5,3,0,0);
        addVec(1,0,0,0,  6,-6,     1,2,-2,      1,6,3,0,0);
        addVec(1,0,0,0,  7,-7,     1,3,-3,      1,7,3,0,0);
        addVec(1,0,0,0,  8,-8,     1,4,-4,      1,8,3,0,0);
        addVec(0,0,1,0,  0,0,      1,4,-4,      0,8,0,1,0);
        addVec(1,0,0,0,  100,-100, 1,8,-8,      1,9,0,0,0);
        addVec(0,0,0,0,  0,0,      1,8,-8,      0,9,0,0,0);
        addVec(1,0,0,0,  -4096,4095, 1,100,-100, 1,10,0,0,0);
        addVec(0,0,0,0,  0,0,      1,100,-100,  0,10,0,0,0);
        addVec(1,0,0,0,  102,-102, 1,-4096,4095, 1,11,0,0,0);

        // Reset state while rst is held.
        #12;
        checkDout("reset", 0, 0);
        checkCtl("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(tbl[i].dv, tbl[i].clr, tbl[i].tl, tbl[i].treq, tbl[i].d0, tbl[i].d1);
            if (tbl[i].chkd) checkDout(tag, tbl[i].e_d0, tbl[i].e_d1);
            checkCtl(tag, tbl[i].e_dv, tbl[i].e_fill, tbl[i].e_tap, tbl[i].e_ack, tbl[i].e_err);
        end

        // Clear with a simultaneous tap load, then raise the tap mid-stream.
        applyStimulus(0, 1, 1, 2, 0, 0);
        checkDout("clr1", 0, 0);
        checkCtl("clr1", 0, 0, 2, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 0, 0, 0, 200 + k, -(200 + k));
            if (k >= 4) checkDout($sformatf("t2_%0d", k), 200 + k - 3, -(200 + k - 3));
            checkCtl($sformatf("t2_%0d", k), k >= 4, k, 2, 0, 0);
        end
        applyStimulus(1, 0, 1, 10, 206, -206);
        checkDout("load10", 203, -203);
        checkCtl("load10", 1, 6, 10, 1, 0);
        for (int k = 7; k <= 13; k++) begin
            applyStimulus(1, 0, 0, 0, 200 + k, -(200 + k));
            if (k >= 12) checkDout($sformatf("t10_%0d", k), 200 + k - 11, -(200 + k - 11));
            checkCtl($sformatf("t10_%0d", k), k >= 12, k, 10, 0, 0);
        end

        // Out-of-range and boundary tap requests, plus back-to-back loads.
        applyStimulus(0, 0, 1, 31, 0, 0);
        checkCtl("req31", 0, 13, 19, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkCtl("idle", 0, 13, 19, 0, 0);
        applyStimulus(0, 0, 1, 20, 0, 0);
        checkCtl("req20", 0, 13, 19, 1, 1);
        applyStimulus(0, 0, 1, 19, 0, 0);
        checkCtl("req19", 0, 13, 19, 1, 0);
        applyStimulus(0, 0, 1, 7, 0, 0);
        checkCtl("req7", 0, 13, 7, 1, 0);
        applyStimulus(0, 0, 1, 9, 0, 0);
        checkCtl("req9", 0, 13, 9, 1, 0);

        // Saturate fill, then flush with a live sample and a tap change.
        for (int j = 1; j <= 10; j++) begin
            applyStimulus(1, 0, 0, 0, 300 + j, -(300 + j));
        end
        checkOutput("sat.fill", int'(fill), DEPTH);
        checkOutput("sat.dout_valid", int'(dout_valid), 1);
        applyStimulus(1, 1, 1, 4, 399, -399);
        checkDout("clr2", 0, 0);
        checkCtl("clr2", 0, 0, 4, 1, 0);
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(1, 0, 0, 0, 400 + j, -(400 + j));
            checkCtl($sformatf("refill_%0d", j), j >= 6, j, 4, 0, 0);
        end
        checkDout("refill", 401, -401);

        // Asynchronous reset pulse between clock edges.
        #2 rst = 1'b1;
        #1;
        checkDout("arst", 0, 0);
        checkCtl("arst", 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 500, -500);
        checkCtl("post1", 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 501, -501);
        checkCtl("post2", 1, 2, 0, 0, 0);
        checkDout("post2", 500, -500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
